uart_rx: RTL and testbench

- 8N1 UART receiver; the receive-side counterpart of the team's uart_tx. Same bit timing parameter, same one-cycle data-valid pulse convention.
- Oversamples the serial line at clk rate and samples each bit at mid-bit.
- Delivers each byte on a parallel bus with a single-cycle valid strobe, and flags framing errors.
- Sits between the board RX pin (or a uart_tx output in loopback) and the consuming logic.

---
 rtl/uart_rx.sv | 159 +++++++++++++++
 tb/tb_uart_rx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver.
// The serial line is oversampled at the clk rate. A falling edge qualified
// at mid start bit opens a frame. Each data bit is then sampled one full bit
// period after the previous sample, so every sample lands near mid-bit.
// A byte is delivered with a one-cycle rx_dv strobe. A low stop bit raises
// a one-cycle frame_err strobe instead. All outputs are registered.
module uart_rx #(
    parameter int CLKS_PER_BIT = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_serial,
    output logic [7:0] rx_data,
    output logic       rx_dv,
    output logic       frame_err,
    output logic       rx_busy
);

    // Counter must hold CLKS_PER_BIT-1; at least one bit wide.
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    logic             sync1_q;
    logic             rx_s_q;
    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [2:0]       bit_idx_q,   bit_idx_d;
    logic [7:0]       shift_q,     shift_d;
    logic [7:0]       rx_data_q,   rx_data_d;
    logic             rx_dv_q,     rx_dv_d;
    logic             frame_err_q, frame_err_d;
    logic             rx_busy_q,   rx_busy_d;

    // Two-flop synchronizer; both flops idle high, matching the idle line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx_serial;
            rx_s_q  <= sync1_q;
        end
    end

    // Next-state, counters, shift register and output strobes.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_dv_d     = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = 3'd0;
                if (!rx_s_q) begin
                    state_d = S_START;
                end
            end

            // Re-check the line at mid start bit to reject short glitches.
            S_START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    state_d   = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // One full bit period after the previous mid-bit point; LSB first.
            S_DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d              = '0;
                    shift_d[bit_idx_q] = rx_s_q;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // The byte is published only when the stop bit is high.
            S_STOP: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_IDLE;
                    if (rx_s_q) begin
                        rx_data_d = shift_q;
                        rx_dv_d   = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // A held-low line (break) parks here, so it reports only one error.
            S_WAIT_IDLE: begin
                cnt_d = '0;
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        rx_busy_d = (state_d != S_IDLE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_dv_q     <= 1'b0;
            frame_err_q <= 1'b0;
            rx_busy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_dv_q     <= rx_dv_d;
            frame_err_q <= frame_err_d;
            rx_busy_q   <= rx_busy_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_dv     = rx_dv_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed testbench for uart_rx at CLKS_PER_BIT=100.
module tb_uart_rx;

    localparam int CPB = 100;
    localparam int H   = (CPB - 1) / 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_serial = 1'b1;
    logic [7:0] rx_data;
    logic       rx_dv;
    logic       frame_err;
    logic       rx_busy;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_serial (rx_serial),
        .rx_data   (rx_data),
        .rx_dv     (rx_dv),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Free-running cycle count, used for latency measurement.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         dv_cnt = 0;
    int         fe_cnt = 0;
    int         both_cnt = 0;
    int         busy_hi = 0;
    int         busy_lo_run = 0;
    int         busy_lo_max = 0;
    int         dv_cyc = 0;
    int         stab_err = 0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] dv_data [0:7];

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rx_dv) begin
            dv_data[dv_cnt % 8] = rx_data;
            dv_cnt++;
            dv_cyc = cyc;
        end
        if (frame_err) fe_cnt++;
        if (rx_dv && frame_err) both_cnt++;
        if (rx_busy) begin
            busy_hi++;
            busy_lo_run = 0;
        end else begin
            busy_lo_run++;
            if (busy_lo_run > busy_lo_max) busy_lo_max = busy_lo_run;
        end
        if (rst_n && (rx_data !== prev_data) && !rx_dv) stab_err++;
        prev_data = rx_data;
    end

    // Clear per-test monitor counters away from the monitor's edge.
    task automatic clear_mon();
        @(posedge clk);
        dv_cnt      = 0;
        fe_cnt      = 0;
        busy_hi     = 0;
        busy_lo_run = 0;
        busy_lo_max = 0;
        for (int i = 0; i < 8; i++) dv_data[i] = 8'hxx;
    endtask

    // Ideal bit-timed driver; called at a falling clock edge.
    task automatic send_byte(input logic [7:0] b, input logic stop_val);
        rx_serial = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_serial = stop_val;
        repeat (CPB) @(negedge clk);
        rx_serial = 1'b1;
    endtask

    int         start_cyc;
    int         lat;
    logic [7:0] v;

    initial begin
        // Reset state
        rst_n = 1'b0;
        rx_serial = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_rx_data", rx_data, 8'h00);
        check_val("rst_rx_dv", rx_dv, 1'b0);
        check_val("rst_frame_err", frame_err, 1'b0);
        check_val("rst_rx_busy", rx_busy, 1'b0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Single frame 0x69 with latency
        clear_mon();
        @(negedge clk);
        start_cyc = cyc;
        send_byte(8'h69, 1'b1);
        repeat (20) @(negedge clk);
        lat = dv_cyc - start_cyc;
        check_val("b69_dv_cnt", dv_cnt, 1);
        check_val("b69_data", dv_data[0], 8'h69);
        check_val("b69_fe_cnt", fe_cnt, 0);
        check_val("b69_latency_ok", ((lat >= 3 + H + 9 * CPB - 1) && (lat <= 3 + H + 9 * CPB + 1)), 1'b1);
        check_val("b69_busy_idle", rx_busy, 1'b0);

        // Back-to-back frames, no idle gap
        clear_mon();
        @(negedge clk);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h5A, 1'b1);
        check_val("b2b_busy_gap_ok", (busy_lo_max <= CPB - H), 1'b1);
        repeat (20) @(negedge clk);
        check_val("b2b_dv_cnt", dv_cnt, 4);
        check_val("b2b_d0", dv_data[0], 8'h00);
        check_val("b2b_d1", dv_data[1], 8'hFF);
        check_val("b2b_d2", dv_data[2], 8'hA5);
        check_val("b2b_d3", dv_data[3], 8'h5A);
        check_val("b2b_fe_cnt", fe_cnt, 0);

        // Start-bit glitch: 20 cycles low
        clear_mon();
        @(negedge clk);
        rx_serial = 1'b0;
        repeat (20) @(negedge clk);
        rx_serial = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check_val("glitch_dv_cnt", dv_cnt, 0);
        check_val("glitch_fe_cnt", fe_cnt, 0);
        check_val("glitch_busy_len_ok", ((busy_hi >= H) && (busy_hi <= H + 3)), 1'b1);
        check_val("glitch_busy_idle", rx_busy, 1'b0);
        check_val("glitch_data_kept", rx_data, 8'h5A);

        // Framing error, then recovery
        clear_mon();
        @(negedge clk);
        send_byte(8'h3C, 1'b0);
        repeat (20) @(negedge clk);
        check_val("ferr_fe_cnt", fe_cnt, 1);
        check_val("ferr_dv_cnt", dv_cnt, 0);
        check_val("ferr_data_kept", rx_data, 8'h5A);
        clear_mon();
        @(negedge clk);
        send_byte(8'h81, 1'b1);
        repeat (20) @(negedge clk);
        check_val("b81_dv_cnt", dv_cnt, 1);
        check_val("b81_data", rx_data, 8'h81);
        check_val("b81_fe_cnt", fe_cnt, 0);

        // Break: line low for 30 bit times
        clear_mon();
        @(negedge clk);
        rx_serial = 1'b0;
        repeat (30 * CPB) @(negedge clk);
        check_val("brk_fe_cnt", fe_cnt, 1);
        check_val("brk_dv_cnt", dv_cnt, 0);
        check_val("brk_busy_held", rx_busy, 1'b1);
        rx_serial = 1'b1;
        repeat (10) @(negedge clk);
        check_val("brk_busy_released", rx_busy, 1'b0);
        check_val("brk_fe_cnt_after", fe_cnt, 1);
        check_val("brk_data_kept", rx_data, 8'h81);

        // Reset during data bit 4 of 0xC3
        v = 8'hC3;
        @(negedge clk);
        rx_serial = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_serial = v[i];
            repeat (CPB) @(negedge clk);
        end
        rx_serial = v[4];
        repeat (CPB / 2) @(negedge clk);
        check_val("mid_busy_before_rst", rx_busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_data", rx_data, 8'h00);
        check_val("mid_rst_dv", rx_dv, 1'b0);
        check_val("mid_rst_fe", frame_err, 1'b0);
        check_val("mid_rst_busy", rx_busy, 1'b0);
        rx_serial = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        clear_mon();
        @(negedge clk);
        send_byte(8'h96, 1'b1);
        repeat (20) @(negedge clk);
        check_val("b96_dv_cnt", dv_cnt, 1);
        check_val("b96_data", rx_data, 8'h96);
        check_val("b96_fe_cnt", fe_cnt, 0);

        // Whole-run properties
        check_val("dv_fe_overlap", both_cnt, 0);
        check_val("data_stable", stab_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog bound on the whole run.
    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
